// File: rtl/gpio_pkg.sv
// rtl/gpio_pkg.sv - register word addresses and debounce counter sizing for gpio_ctrl
package gpio_pkg;

  localparam logic [2:0] GPIO_REG_IN      = 3'd0;
  localparam logic [2:0] GPIO_REG_OUT     = 3'd1;
  localparam logic [2:0] GPIO_REG_DIR     = 3'd2;
  localparam logic [2:0] GPIO_REG_RISE_EN = 3'd3;
  localparam logic [2:0] GPIO_REG_FALL_EN = 3'd4;
  localparam logic [2:0] GPIO_REG_STATUS  = 3'd5;

  function automatic int cnt_width(input int cycles);
    return $clog2(cycles);
  endfunction

endpackage

// File: rtl/gpio_debounce.sv
// rtl/gpio_debounce.sv - one pin: input synchroniser plus optional debouncer (GPIO_DEBOUNCE_EN)
// Without GPIO_DEBOUNCE_EN the stable value is the synchroniser output itself.
module gpio_debounce
  import gpio_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic din,
  output logic stb
);

  logic [SYNC_STAGES-1:0] sync;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], din};
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam int CW = cnt_width(DEBOUNCE_CYCLES);

  logic [CW-1:0] cnt;

  // The counter only runs while the synchronised value disagrees with stb.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt <= '0;
      stb <= 1'b0;
    end else if (sync[SYNC_STAGES-1] == stb) begin
      cnt <= '0;
    end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      stb <= sync[SYNC_STAGES-1];
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end
`else
  assign stb = sync[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/gpio_ctrl.sv
// rtl/gpio_ctrl.sv - memory-mapped GPIO controller with edge capture and level interrupt
// Debounce per pin is built only when GPIO_DEBOUNCE_EN is defined.
module gpio_ctrl
  import gpio_pkg::*;
#(
  parameter int WIDTH           = 32,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cs_i,
  input  logic             we_i,
  input  logic [2:0]       addr_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o,
  output logic             ack_o,
  input  logic [WIDTH-1:0] gpio_i,
  output logic [WIDTH-1:0] gpio_o,
  output logic [WIDTH-1:0] gpio_oe_o,
  output logic             irq_o
);

  logic [WIDTH-1:0] stb;
  logic [WIDTH-1:0] stb_q;
  logic [WIDTH-1:0] out_r;
  logic [WIDTH-1:0] dir_r;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] status;
  logic [WIDTH-1:0] edge_set;
  logic [WIDTH-1:0] w1c;
  logic [31:0]      rd_mux;
  logic             wr;

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    gpio_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .din  (gpio_i[i]),
      .stb  (stb[i])
    );
  end

  assign wr = cs_i & we_i;

  // Pins configured as outputs never capture edges.
  assign edge_set = ~dir_r & ((stb & ~stb_q & rise_en) | (~stb & stb_q & fall_en));
  assign w1c      = (wr && addr_i == GPIO_REG_STATUS) ? wdata_i[WIDTH-1:0] : '0;

  always_comb begin
    rd_mux = '0;
    case (addr_i)
      GPIO_REG_IN:      rd_mux[WIDTH-1:0] = stb;
      GPIO_REG_OUT:     rd_mux[WIDTH-1:0] = out_r;
      GPIO_REG_DIR:     rd_mux[WIDTH-1:0] = dir_r;
      GPIO_REG_RISE_EN: rd_mux[WIDTH-1:0] = rise_en;
      GPIO_REG_FALL_EN: rd_mux[WIDTH-1:0] = fall_en;
      GPIO_REG_STATUS:  rd_mux[WIDTH-1:0] = status;
      default:          rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stb_q   <= '0;
      out_r   <= '0;
      dir_r   <= '0;
      rise_en <= '0;
      fall_en <= '0;
      status  <= '0;
      irq_o   <= 1'b0;
      ack_o   <= 1'b0;
      rdata_o <= '0;
    end else begin
      stb_q   <= stb;
      // A new edge in the same cycle as its W1C keeps the bit set.
      status  <= (status & ~w1c) | edge_set;
      irq_o   <= |status;
      ack_o   <= cs_i;
      rdata_o <= (cs_i && !we_i) ? rd_mux : '0;
      if (wr) begin
        case (addr_i)
          GPIO_REG_OUT:     out_r   <= wdata_i[WIDTH-1:0];
          GPIO_REG_DIR:     dir_r   <= wdata_i[WIDTH-1:0];
          GPIO_REG_RISE_EN: rise_en <= wdata_i[WIDTH-1:0];
          GPIO_REG_FALL_EN: fall_en <= wdata_i[WIDTH-1:0];
          default: ;
        endcase
      end
    end
  end

  assign gpio_o    = out_r;
  assign gpio_oe_o = dir_r;

endmodule

// File: tb/tb_gpio_ctrl.sv
// tb/tb_gpio_ctrl.sv - directed self-checking bench for gpio_ctrl (either GPIO_DEBOUNCE_EN build)
module tb_gpio_ctrl;

  localparam int W  = 32;
  localparam int SS = 2;
  localparam int DC = 8;
`ifdef GPIO_DEBOUNCE_EN
  localparam int DEB = DC;
`else
  localparam int DEB = 0;
`endif
  localparam int LAT        = SS + DEB;
  localparam int GLITCH     = (DEB > 1) ? DEB - 1 : 1;
  localparam logic [31:0] EXP_GLITCH = (DEB > 1) ? 32'h0 : 32'h8;

  localparam logic [2:0] A_IN = 3'd0, A_OUT = 3'd1, A_DIR = 3'd2;
  localparam logic [2:0] A_RISE = 3'd3, A_FALL = 3'd4, A_STATUS = 3'd5;

  logic          clk = 1'b0;
  logic          rst;
  logic          cs = 1'b0;
  logic          we = 1'b0;
  logic [2:0]    addr = '0;
  logic [31:0]   wdata = '0;
  logic [31:0]   rdata, rdata8;
  logic          ack, ack8;
  logic [W-1:0]  gpio_i = '0;
  logic [W-1:0]  gpio_o, gpio_oe;
  logic          irq, irq8;
  logic [7:0]    gpio8_o, gpio8_oe;
  logic [31:0]   rd, rd8;
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  gpio_ctrl #(.WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC)) dut (
    .clk_i(clk), .rst_i(rst), .cs_i(cs), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .rdata_o(rdata), .ack_o(ack), .gpio_i(gpio_i), .gpio_o(gpio_o),
    .gpio_oe_o(gpio_oe), .irq_o(irq)
  );

  gpio_ctrl #(.WIDTH(8), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC)) dut8 (
    .clk_i(clk), .rst_i(rst), .cs_i(cs), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .rdata_o(rdata8), .ack_o(ack8), .gpio_i(gpio_i[7:0]), .gpio_o(gpio8_o),
    .gpio_oe_o(gpio8_oe), .irq_o(irq8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
    cs = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(posedge clk);
    #1;
    cs = 1'b0; we = 1'b0;
    check("wr_ack", 32'(ack), 32'h1);
  endtask

  task automatic bus_rd(input logic [2:0] a, output logic [31:0] d, output logic [31:0] d8);
    cs = 1'b1; we = 1'b0; addr = a;
    @(posedge clk);
    #1;
    cs = 1'b0;
    check("rd_ack", 32'(ack), 32'h1);
    d  = rdata;
    d8 = rdata8;
  endtask

  initial begin
    rst    = 1'b1;
    gpio_i = '1;
    #1;
    check("rst_gpio_o", gpio_o, 32'h0);
    check("rst_oe", gpio_oe, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_rdata", rdata, 32'h0);
    tick(2);
    rst = 1'b0;

    // Input latency: stb is still 0 one cycle short of SS+DEB.
    tick(LAT - 1);
    bus_rd(A_IN, rd, rd8);
    check("in_early", rd, 32'h0);
    bus_rd(A_IN, rd, rd8);
    check("in_settled", rd, 32'hFFFF_FFFF);
    bus_rd(A_STATUS, rd, rd8);
    check("status_init", rd, 32'h0);
    check("irq_init", 32'(irq), 32'h0);

    // Output path, back-to-back writes.
    bus_wr(A_DIR, 32'h0000_FFFF);
    check("oe_wr", gpio_oe, 32'h0000_FFFF);
    bus_wr(A_OUT, 32'hA5A5_5A5A);
    check("out_wr", gpio_o, 32'hA5A5_5A5A);
    tick(1);
    check("ack_drop", 32'(ack), 32'h0);
    check("rdata_idle", rdata, 32'h0);
    bus_rd(A_OUT, rd, rd8);
    check("out_rd", rd, 32'hA5A5_5A5A);
    check("out_rd_w8", rd8, 32'h0000_005A);
    bus_rd(A_DIR, rd, rd8);
    check("dir_rd", rd, 32'h0000_FFFF);

    bus_wr(A_DIR, 32'h0);
    gpio_i = '0;
    tick(LAT + 2);
    bus_rd(A_IN, rd, rd8);
    check("in_low", rd, 32'h0);

    // Rising edge on pin 3: glitch then real hold.
    bus_wr(A_RISE, 32'h8);
    gpio_i[3] = 1'b1;
    tick(GLITCH);
    gpio_i[3] = 1'b0;
    tick(LAT + 3);
    bus_rd(A_STATUS, rd, rd8);
    check("glitch", rd, EXP_GLITCH);
    bus_wr(A_STATUS, 32'hFFFF_FFFF);
    tick(2);
    check("irq_clean", 32'(irq), 32'h0);
    gpio_i[3] = 1'b1;
    tick(LAT + 1);
    check("irq_not_yet", 32'(irq), 32'h0);
    tick(1);
    check("irq_rise", 32'(irq), 32'h1);
    bus_rd(A_STATUS, rd, rd8);
    check("status_rise", rd, 32'h8);

    // W1C lands in the same cycle as a new rising edge.
    gpio_i[3] = 1'b0;
    tick(LAT + 2);
    gpio_i[3] = 1'b1;
    tick(LAT);
    bus_wr(A_STATUS, 32'h8);
    bus_rd(A_STATUS, rd, rd8);
    check("set_wins", rd, 32'h8);
    check("irq_set_wins", 32'(irq), 32'h1);
    bus_wr(A_RISE, 32'h0);
    bus_rd(A_STATUS, rd, rd8);
    check("en_clear_keeps", rd, 32'h8);
    bus_wr(A_STATUS, 32'h8);
    check("irq_hold", 32'(irq), 32'h1);
    tick(1);
    check("irq_fall", 32'(irq), 32'h0);
    bus_rd(A_STATUS, rd, rd8);
    check("status_cleared", rd, 32'h0);

    // Output pin ignores edges; falling edge on an input pin.
    bus_wr(A_DIR, 32'h20);
    bus_wr(A_RISE, 32'h20);
    bus_wr(A_FALL, 32'h10);
    gpio_i[4] = 1'b1;
    gpio_i[5] = 1'b1;
    tick(LAT + 3);
    bus_rd(A_STATUS, rd, rd8);
    check("dir_out_no_edge", rd, 32'h0);
    gpio_i[4] = 1'b0;
    tick(LAT + 3);
    bus_rd(A_STATUS, rd, rd8);
    check("fall", rd, 32'h10);
    bus_wr(A_STATUS, 32'h10);
    bus_rd(A_STATUS, rd, rd8);
    check("fall_cleared", rd, 32'h0);

    // Unmapped addresses.
    bus_rd(3'd7, rd, rd8);
    check("rd_addr7", rd, 32'h0);
    bus_wr(3'd6, 32'hFFFF_FFFF);
    bus_rd(3'd6, rd, rd8);
    check("rd_addr6", rd, 32'h0);
    bus_rd(A_OUT, rd, rd8);
    check("wr6_out", rd, 32'hA5A5_5A5A);
    bus_rd(A_DIR, rd, rd8);
    check("wr6_dir", rd, 32'h20);
    bus_rd(A_RISE, rd, rd8);
    check("wr6_rise", rd, 32'h20);
    check("wr6_gpio_o", gpio_o, 32'hA5A5_5A5A);

    // Asynchronous reset in the middle of a debounce count.
    gpio_i[0] = 1'b1;
    tick((LAT > 2) ? LAT - 2 : 0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_gpio_o", gpio_o, 32'h0);
    check("arst_oe", gpio_oe, 32'h0);
    check("arst_irq", 32'(irq), 32'h0);
    check("arst_rdata", rdata, 32'h0);
    tick(1);
    rst = 1'b0;
    tick(LAT - 1);
    bus_rd(A_IN, rd, rd8);
    check("arst_in_early", rd, 32'h0);
    bus_rd(A_IN, rd, rd8);
    check("arst_in_settled", rd, 32'h29);
    bus_rd(A_STATUS, rd, rd8);
    check("arst_status", rd, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpio_ctrl.md
# gpio_ctrl

Parametrised memory-mapped GPIO controller for the MIPS SoC; replaces the fixed 32-bit LED/switch bundle with a per-pin-direction port of configurable width. Sits on the CPU peripheral bus next to the UART and PS/2 blocks. Each pin has:
- an input synchroniser;
- optional debounce;
- rising/falling edge capture into a write-1-to-clear status register that drives a level interrupt to the CPU.

## Interface
- `WIDTH`, 32: number of GPIO pins, 1..32; register bits above `WIDTH-1` read 0, writes ignored.
- `SYNC_STAGES`, 2: input synchroniser depth, ≥2.
- `DEBOUNCE_CYCLES`, 50000: cycles an input must hold a new value before it is accepted; 1 ms at 50 MHz; ≥2.

Ports (clock and reset first):
- `clk_i`  in  1  system clock.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `cs_i`  in  1  bus select, one-cycle request.
- `we_i`  in  1  1 = write, 0 = read; sampled with `cs_i`.
- `addr_i`  in  3  word address (byte address [4:2]).
- `wdata_i`  in  32  write data.
- `rdata_o`  out  32  read data, valid while `ack_o`=1.
- `ack_o`  out  1  one-cycle acknowledge.
- `gpio_i`  in  WIDTH  pad inputs (asynchronous).
- `gpio_o`  out  WIDTH  pad output values.
- `gpio_oe_o`  out  WIDTH  pad output enables, 1 = drive.
- `irq_o`  out  1  level interrupt, registered.

## Operation
Register map (word address, reset value):
- 0 `IN` (RO): debounced pin values.
- 1 `OUT` (RW, 0): drives `gpio_o`.
- 2 `DIR` (RW, 0): drives `gpio_oe_o`; 1 = output.
- 3 `RISE_EN` (RW, 0): enables rising-edge capture.
- 4 `FALL_EN` (RW, 0): enables falling-edge capture.
- 5 `STATUS` (R/W1C, 0): captured edges.
- 6–7: read 0, writes ignored.

Input path, per pin:
- `SYNC_STAGES` flops, then the debouncer, producing a stable value `stb`.
- Debouncer: counter clears whenever the synchronised value equals `stb`. While they differ, the counter increments. When it reaches `DEBOUNCE_CYCLES-1` and they still differ, `stb` takes the new value and the counter clears.
- A glitch shorter than `DEBOUNCE_CYCLES` cycles never reaches `stb`.

Edge capture:
- `stb` 0→1 with `RISE_EN[n]`=1 and `DIR[n]`=0 sets `STATUS[n]`.
- 1→0 with `FALL_EN[n]`=1 does likewise.
- An edge and a W1C of the same bit in the same cycle: set wins.
- Clearing an enable does not clear existing status.

Interrupt: `irq_o` = OR of `STATUS`, registered.

Bus:
- Every `cs_i` cycle is acknowledged, mapped or not.
- Back-to-back requests are accepted every cycle.

Reset values: all registers 0, `stb` 0, synchronisers 0, counters 0, `gpio_o` 0, `gpio_oe_o` 0, `irq_o` 0, `ack_o` 0, `rdata_o` 0. Reset mid-debounce discards the count.

## Timing
- Writes: register updates at the `cs_i` edge; `gpio_o`/`gpio_oe_o` change 1 cycle after the request; `ack_o` is high the cycle after `cs_i`.
- Reads: `rdata_o` is registered and valid with `ack_o` 1 cycle after `cs_i`; it is 0 when `ack_o`=0.
- Input latency, pad change to `IN`: `SYNC_STAGES + DEBOUNCE_CYCLES` cycles with debounce, `SYNC_STAGES` cycles without.
- `STATUS` sets in the cycle after `stb` changes; `irq_o` rises 1 cycle after that.
- W1C of the last set bit: `irq_o` falls 2 cycles after `cs_i`.

## Configuration
- `GPIO_DEBOUNCE_EN` defined: debouncer instantiated per pin as above.
- Not defined: `stb` is the synchroniser output directly; no counters; `DEBOUNCE_CYCLES` is ignored.

## Structure
- Package `gpio_pkg`: register word-address constants (`GPIO_REG_IN` … `GPIO_REG_STATUS`) and the counter-width function, `$clog2(DEBOUNCE_CYCLES)`.
- Sub-module `gpio_debounce`: one pin, containing the synchroniser, counter and `stb`. It is instantiated `WIDTH` times in a generate loop; the top level holds registers, edge detect and bus logic.

## Test plan
- Reset with `gpio_i`=all-ones and enables at 0 → after `SYNC_STAGES+DEBOUNCE_CYCLES` cycles `IN` reads all-ones, `STATUS`=0, `irq_o`=0.
- Write `DIR`=0x0000_FFFF, `OUT`=0xA5A5_5A5A → `gpio_oe_o`=0xFFFF and `gpio_o`=0xA5A5_5A5A one cycle after each request; readback matches; `ack_o` asserted exactly one cycle per request.
- `RISE_EN[3]`=1; pulse `gpio_i[3]` high for `DEBOUNCE_CYCLES-1` cycles → no `STATUS`. Hold it for `DEBOUNCE_CYCLES+5` cycles → `STATUS`=0x8 and `irq_o`=1.
- W1C 0x8 on the same cycle as a new rising edge on pin 3 → `STATUS[3]` stays 1 (set wins). A later W1C 0x8 → `irq_o`=0 two cycles after `cs_i`.
- Edge on a pin with `DIR`=1 → no status. Read addr 7 → 0; write addr 6 → no register changes; `WIDTH`=8 build: `OUT` readback upper 24 bits are 0.
- Assert `rst_i` mid-debounce, asynchronously between clock edges → all outputs 0 immediately. After release, a full `DEBOUNCE_CYCLES` hold is required again.
